// File: rtl/packet_tx.sv
// UART-style transmit serializer: start bit, 8 data bits LSB first, optional parity, stop bit.
// Define PACKET_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module packet_tx #(
    parameter int unsigned CLKS_PER_BIT = 10
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       serial_out,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

`ifdef PACKET_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
`endif

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    data_q, data_d;
    logic          serial_q, serial_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          bit_end;
`ifdef PACKET_TX_PARITY_EN
    logic          parity_q, parity_d;
`endif

    assign bit_end = (timer_q == LAST);

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        idx_d    = idx_q;
        data_d   = data_q;
        serial_d = serial_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
`ifdef PACKET_TX_PARITY_EN
        parity_d = parity_q;
`endif
        if (state_q != IDLE) begin
            timer_d = bit_end ? '0 : timer_q + TW'(1);
        end
        case (state_q)
            IDLE: begin
                serial_d = 1'b1;
                busy_d   = 1'b0;
                timer_d  = '0;
                if (tx_start) begin
                    data_d   = tx_data;
`ifdef PACKET_TX_PARITY_EN
                    parity_d = ^tx_data;
`endif
                    state_d  = START;
                    serial_d = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d  = DATA;
                    serial_d = data_q[0];
                    idx_d    = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    // The next bit on the line is data_q[1], i.e. bit 0 after this shift.
                    data_d = data_q >> 1;
                    idx_d  = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef PACKET_TX_PARITY_EN
                        state_d  = PARITY;
                        serial_d = parity_q;
`else
                        state_d  = STOP;
                        serial_d = 1'b1;
`endif
                    end else begin
                        serial_d = data_q[1];
                    end
                end
            end
`ifdef PACKET_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d  = STOP;
                    serial_d = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    state_d  = IDLE;
                    serial_d = 1'b1;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                serial_d = 1'b1;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            idx_q    <= '0;
            data_q   <= '0;
            serial_q <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef PACKET_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            serial_q <= serial_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef PACKET_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign serial_out = serial_q;
    assign tx_busy    = busy_q;
    assign tx_done    = done_q;

endmodule
